// File: rtl/call_register.sv
// call_register
//   Front end of the elevator controller. Synchronizes and debounces the raw
//   hall-call and cabin-call buttons into latched pending-call bitmaps,
//   encodes the one-hot floor sensors into a binary floor number, and clears
//   a floor's calls when the cabin stands still at that floor.
//
// Ports
//   clk                  : single clock, rising-edge state updates
//   reset                : asynchronous, active-low reset
//   request_buttons_raw  : raw hall-call buttons, bit i = floor i (async)
//   elevator_buttons_raw : raw cabin buttons, bit i = floor i (async)
//   floor_sensors        : one-hot floor sensors, synchronous to clk
//   move                 : 1 while the cabin is moving (from elevatorControl)
//   request_pending      : latched hall calls
//   cabin_pending        : latched cabin calls
//   any_pending          : OR of both pending vectors
//   current_floor        : binary index of the last valid floor
//   floor_valid          : exactly one sensor bit was set (registered)
//   arrived              : one-cycle pulse when a floor starts being served
//   sensor_fault         : sticky flag, more than one sensor bit seen

module call_register #(
  parameter int FLOORS          = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FLOOR_W         = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  request_buttons_raw,
  input  logic [FLOORS-1:0]  elevator_buttons_raw,
  input  logic [FLOORS-1:0]  floor_sensors,
  input  logic               move,
  output logic [FLOORS-1:0]  request_pending,
  output logic [FLOORS-1:0]  cabin_pending,
  output logic               any_pending,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               floor_valid,
  output logic               arrived,
  output logic               sensor_fault
);

  // Hall buttons occupy the low FLOORS bits, cabin buttons the high ones.
  localparam int NB    = 2 * FLOORS;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  // Value the counter holds on the cycle whose edge makes it reach CNT_MAX.
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]      s1_q, s1_d;
  logic [NB-1:0]      s2_q, s2_d;
  logic [CNT_W-1:0]   cnt_q [NB];
  logic [CNT_W-1:0]   cnt_d [NB];
  logic [NB-1:0]      armed_q, armed_d;
  logic [NB-1:0]      press_s;

  logic [FLOORS-1:0]  req_pend_q, req_pend_d;
  logic [FLOORS-1:0]  cab_pend_q, cab_pend_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
  logic               floor_valid_q, floor_valid_d;
  logic               fault_q, fault_d;
  logic               arrived_q, arrived_d;
  logic               svc_prev_q, svc_prev_d;
  logic [FLOOR_W-1:0] svc_floor_q, svc_floor_d;

  logic               multi_s;
  logic               one_hot_s;
  logic [FLOOR_W-1:0] sensor_idx_s;
  logic               svc_s;
  logic               clr_s;

  // Synchronizer chain and per-bit debounce counters with press detection.
  always_comb begin
    s1_d    = {elevator_buttons_raw, request_buttons_raw};
    s2_d    = s1_q;
    press_s = '0;
    armed_d = armed_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i]) begin
        // A press fires only once per hold: the flag stays low until release.
        press_s[i] = armed_q[i] & (cnt_q[i] == CNT_ARM);
        armed_d[i] = armed_q[i] & ~press_s[i];
        if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b1;
      end
    end
  end

  // Floor sensor decode: one-hot check, binary encode, sticky fault.
  always_comb begin
    // x & (x-1) is non-zero exactly when two or more bits are set.
    multi_s      = |(floor_sensors & (floor_sensors - FLOORS'(1)));
    one_hot_s    = (floor_sensors != '0) & ~multi_s;
    sensor_idx_s = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (floor_sensors[i]) begin
        sensor_idx_s = FLOOR_W'(i);
      end else begin
        sensor_idx_s = sensor_idx_s;
      end
    end
    if (one_hot_s) begin
      cur_floor_d = sensor_idx_s;
    end else begin
      cur_floor_d = cur_floor_q;
    end
    floor_valid_d = one_hot_s;
    fault_d       = fault_q | multi_s;
  end

  // Service, pending-bit update (clear beats set) and arrival pulse.
  always_comb begin
    svc_s      = floor_valid_q & ~move;
    req_pend_d = req_pend_q;
    cab_pend_d = cab_pend_q;
    clr_s      = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      clr_s = svc_s & (cur_floor_q == FLOOR_W'(i));
      if (clr_s) begin
        req_pend_d[i] = 1'b0;
        cab_pend_d[i] = 1'b0;
      end else begin
        req_pend_d[i] = req_pend_q[i] | press_s[i];
        cab_pend_d[i] = cab_pend_q[i] | press_s[FLOORS+i];
      end
    end
    // Pulse when service starts, or when the served floor changes under it.
    arrived_d   = svc_s & (~svc_prev_q | (cur_floor_q != svc_floor_q));
    svc_prev_d  = svc_s;
    svc_floor_d = cur_floor_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      armed_q       <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
      req_pend_q    <= '0;
      cab_pend_q    <= '0;
      cur_floor_q   <= '0;
      floor_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      arrived_q     <= 1'b0;
      svc_prev_q    <= 1'b0;
      svc_floor_q   <= '0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      armed_q       <= armed_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      req_pend_q    <= req_pend_d;
      cab_pend_q    <= cab_pend_d;
      cur_floor_q   <= cur_floor_d;
      floor_valid_q <= floor_valid_d;
      fault_q       <= fault_d;
      arrived_q     <= arrived_d;
      svc_prev_q    <= svc_prev_d;
      svc_floor_q   <= svc_floor_d;
    end
  end

  assign request_pending = req_pend_q;
  assign cabin_pending   = cab_pend_q;
  assign any_pending     = (|req_pend_q) | (|cab_pend_q);
  assign current_floor   = cur_floor_q;
  assign floor_valid     = floor_valid_q;
  assign arrived         = arrived_q;
  assign sensor_fault    = fault_q;

endmodule

// File: tb/tb_call_register.sv
// Directed bench for call_register: a vector table plus hand-written
// sequences for reset latency and reset during a half-debounced press.

module tb_call_register;

  logic       clk;
  logic       reset;
  logic [4:0] request_buttons_raw;
  logic [4:0] elevator_buttons_raw;
  logic [4:0] floor_sensors;
  logic       move;
  logic [4:0] request_pending;
  logic [4:0] cabin_pending;
  logic       any_pending;
  logic [2:0] current_floor;
  logic       floor_valid;
  logic       arrived;
  logic       sensor_fault;

  int n_app;
  int n_bad;

  call_register #(.FLOORS(5), .DEBOUNCE_CYCLES(4), .FLOOR_W(3)) dut (
    .clk                  (clk),
    .reset                (reset),
    .request_buttons_raw  (request_buttons_raw),
    .elevator_buttons_raw (elevator_buttons_raw),
    .floor_sensors        (floor_sensors),
    .move                 (move),
    .request_pending      (request_pending),
    .cabin_pending        (cabin_pending),
    .any_pending          (any_pending),
    .current_floor        (current_floor),
    .floor_valid          (floor_valid),
    .arrived              (arrived),
    .sensor_fault         (sensor_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] req;
    logic [4:0] cab;
    logic [4:0] sens;
    logic       mv;
    int         edges;
    logic [4:0] rp;
    logic [4:0] cp;
    logic [2:0] cf;
    logic       fv;
    logic       arr;
    logic       flt;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_app++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] rp, input logic [4:0] cp,
                         input logic [2:0] cf, input logic fv, input logic arr,
                         input logic flt);
    chk({tag, ".request_pending"}, 32'(request_pending), 32'(rp));
    chk({tag, ".cabin_pending"},   32'(cabin_pending),   32'(cp));
    chk({tag, ".any_pending"},     32'(any_pending),     32'((|rp) | (|cp)));
    chk({tag, ".current_floor"},   32'(current_floor),   32'(cf));
    chk({tag, ".floor_valid"},     32'(floor_valid),     32'(fv));
    chk({tag, ".arrived"},         32'(arrived),         32'(arr));
    chk({tag, ".sensor_fault"},    32'(sensor_fault),    32'(flt));
  endtask

  // Advance n rising edges, leaving time 1 unit after the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_app = 0;
    n_bad = 0;

    //        req       cab       sens      mv    edges rp        cp        cf    fv    arr   flt
    vecs[0]  = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 3, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 6, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 5, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 1, 5'b00010, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 4, 5'b00010, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'b00000, 5'b00000, 5'b00010, 1'b1, 1, 5'b00010, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{5'b00000, 5'b00000, 5'b00010, 1'b1, 2, 5'b00010, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{5'b00000, 5'b00000, 5'b00010, 1'b0, 1, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{5'b00000, 5'b00000, 5'b00010, 1'b0, 1, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{5'b00000, 5'b00010, 5'b00010, 1'b0, 7, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{5'b00000, 5'b00000, 5'b00010, 1'b0, 3, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{5'b00000, 5'b00000, 5'b00001, 1'b0, 1, 5'b00000, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{5'b00000, 5'b00000, 5'b00001, 1'b0, 1, 5'b00000, 5'b00000, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{5'b10000, 5'b00001, 5'b00001, 1'b0, 6, 5'b10000, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{5'b00000, 5'b00000, 5'b00001, 1'b1, 3, 5'b10000, 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{5'b00000, 5'b00000, 5'b00100, 1'b1, 1, 5'b10000, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 1, 5'b10000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{5'b00000, 5'b00000, 5'b01000, 1'b1, 1, 5'b10000, 5'b00000, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{5'b00000, 5'b00000, 5'b10000, 1'b1, 1, 5'b10000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 1, 5'b10000, 5'b00000, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 2, 5'b10000, 5'b00000, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{5'b00000, 5'b00000, 5'b10001, 1'b0, 1, 5'b10000, 5'b00000, 3'd4, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{5'b00000, 5'b00000, 5'b10000, 1'b1, 1, 5'b10000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[23] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 2, 5'b10000, 5'b00000, 3'd4, 1'b0, 1'b0, 1'b1};
    vecs[24] = '{5'b00100, 5'b00000, 5'b00000, 1'b1, 6, 5'b10100, 5'b00000, 3'd4, 1'b0, 1'b0, 1'b1};

    // Reset held with every input high: all outputs stay at zero.
    reset                = 1'b0;
    request_buttons_raw  = 5'b11111;
    elevator_buttons_raw = 5'b11111;
    floor_sensors        = 5'b11111;
    move                 = 1'b1;
    step(3);
    chk_all("rst_hold", 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);

    // Release: sensor update after edge 1, pending bit after edge 6.
    reset                = 1'b1;
    request_buttons_raw  = 5'b00100;
    elevator_buttons_raw = 5'b00000;
    floor_sensors        = 5'b00100;
    move                 = 1'b1;
    step(1);
    chk_all("rel_e1", 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("rel_e5", 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_all("rel_e6", 5'b00100, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0);

    // Clean restart for the vector table.
    reset                = 1'b0;
    request_buttons_raw  = 5'b00000;
    elevator_buttons_raw = 5'b00000;
    floor_sensors        = 5'b00000;
    move                 = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    chk_all("restart", 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      request_buttons_raw  = vecs[i].req;
      elevator_buttons_raw = vecs[i].cab;
      floor_sensors        = vecs[i].sens;
      move                 = vecs[i].mv;
      step(vecs[i].edges);
      chk_all($sformatf("v%0d", i), vecs[i].rp, vecs[i].cp, vecs[i].cf,
              vecs[i].fv, vecs[i].arr, vecs[i].flt);
    end

    // Half-debounced cabin press on floor 1, then reset mid-cycle.
    request_buttons_raw  = 5'b00000;
    elevator_buttons_raw = 5'b00010;
    floor_sensors        = 5'b00000;
    move                 = 1'b1;
    step(4);
    chk_all("half_press", 5'b10100, 5'b00000, 3'd4, 1'b0, 1'b0, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk_all("mid_reset", 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step(2);
    reset = 1'b1;
    // Still held after release: needs the full DEBOUNCE_CYCLES+2 edges again.
    step(5);
    chk_all("post_rst_e5", 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("post_rst_e6", 5'b00000, 5'b00010, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
    $finish;
  end

endmodule
